oc8051_cxrom_prefetch: RTL and testbench
========================================

# oc8051_cxrom_prefetch

Fetch-side initiator for the 8051 code ROM port. It issues byte addresses to the cxrom word interface, accepts 32-bit little-endian words and queues them in an 8-byte prefetch buffer. It presents the next three code bytes to the decoder and retires 1–3 bytes per cycle. It sits between the decoder/PC logic and the cxrom responder, and handles PC redirects (jumps, interrupts) by flushing the buffer and discarding any in-flight word.

## Interface
Parameters: none.

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- pc_load  in  1  redirect strobe; flush and restart fetch at pc_in
- pc_in  in  16  redirect target byte address
- cxrom_req  out  1  word request valid
- cxrom_addr  out  16  byte address of requested word; byte0 = addr, byte3 = addr+3
- cxrom_ack  in  1  responder accepts request; cxrom_data_in valid the same cycle
- cxrom_data_in  in  32  {addr+3, addr+2, addr+1, addr}
- op_valid  out  1  at least 3 bytes buffered
- op0, op1, op2  out  8 each  bytes at op_pc, op_pc+1, op_pc+2; 0 when op_valid=0
- op_pc  out  16  address of op0
- op_adv  in  2  bytes retired this cycle (0–3); ignored when op_valid=0
- fetch_cnt  out  16  accepted-word counter (see Configuration)

## Operation
- Buffer: 8 × 8-bit circular array, 3-bit head pointer, 4-bit count (0..8). The tail is head+count mod 8.
- Fetch address register fetch_addr: 16-bit. It advances by 4 mod 2^16 on each accepted, non-discarded ack. No alignment is required.
- FSM states:
  - IDLE: no outstanding request. Go to REQ when count_after_retire ≤ 4.
  - REQ: cxrom_req=1, cxrom_addr=fetch_addr held stable. On ack, write 4 bytes at tail, count += 4, fetch_addr += 4. Then go to REQ again if the new count ≤ 4, else IDLE.
  - DISCARD: entered on pc_load while in REQ with no ack that cycle. cxrom_req and cxrom_addr stay held at the old address until ack. The ack data is dropped. Then go to REQ at the new fetch_addr.
- Retire: when op_valid and op_adv≠0, head += op_adv, count −= op_adv, op_pc += op_adv mod 2^16. A fill and a retire in the same cycle give count_next = count − adv + 4, which never exceeds 8 by the issue rule.
- op_adv greater than count cannot occur while op_valid=1, because count ≥ 3.
- pc_load has priority over retire and fill. In one cycle it sets count=0, head=0, op_pc=pc_in and fetch_addr=pc_in.
  - In REQ without a same-cycle ack: go to DISCARD.
  - In REQ with a same-cycle ack: the data is dropped and the next state is REQ at pc_in.
- op_pc wrap: 0xFFFF+1 → 0x0000. fetch_addr wraps the same way; the word at 0xFFFE covers 0xFFFE, 0xFFFF, 0x0000, 0x0001.

## Timing
- Reset values:
  - cxrom_req=0, cxrom_addr=0
  - op_valid=0, op0–op2=0, op_pc=0
  - fetch_cnt=0
  - count=0, head=0, fetch_addr=0, state IDLE
- First cycle after rst deasserts: FSM moves to REQ. cxrom_req=1 with addr 0x0000 from the second cycle.
- Fill latency: ack in cycle N → bytes visible and op_valid=1 in cycle N+1 (count 4 ≥ 3).
- Redirect latency: pc_load in cycle N with no request outstanding → cxrom_req=1, addr=pc_in in N+1. With zero-wait ack, op_valid=1 in N+2.
- At most one request is outstanding. cxrom_addr is stable from req rise until the ack cycle inclusive.
- op_valid, op0–op2 and op_pc are registered-state functions only. There is no combinational path from op_adv or cxrom_ack to them.
- rst mid-request: cxrom_req drops the next cycle. The responder must tolerate an abandoned request.

## Configuration
- OC8051_CXROM_PREFETCH_CNT_EN defined: fetch_cnt counts non-discarded accepted words. It saturates at 0xFFFF and is cleared by rst only (not by pc_load).
- Not defined: fetch_cnt is tied to 16'h0000 and no counter flops are built.

## Test plan
- Reset then ack every request with zero wait, ROM[i]=i[7:0]. Required: first req at addr 0x0000. op_valid at cycle 3 with op0..op2=00,01,02 and op_pc=0.
- op_adv=3 every cycle with acks always asserted. Required: op_pc sequence 0,3,6,…; bytes match the address low bytes; no overflow; count never exceeds 8.
- Responder stalls ack for 5 cycles while op_adv=1. Required: op_valid drops when count<3, cxrom_addr is held constant, and no bytes are lost.
- pc_load with pc_in=0x1234 in the cycle before a delayed ack (in REQ, no ack). Required: the old word is discarded and the next req is at 0x1234. op0=0x34 after the fill; with the macro, fetch_cnt does not count the discarded word.
- pc_load with pc_in=0xFFFE. Required: op0..op2 = ROM[0xFFFE], ROM[0xFFFF], ROM[0x0000]; after op_adv=3, op_pc=0x0001.
- pc_load together with a same-cycle ack, and rst asserted mid-REQ. Required: the ack data is dropped with the next req at pc_in; rst returns all outputs to their reset values the following cycle.

Source files
------------

// File: rtl/oc8051_cxrom_prefetch.sv
// Code-ROM prefetcher: fetches 32-bit words from cxrom into an 8-byte ring and presents a
// 3-byte decode window. Define OC8051_CXROM_PREFETCH_CNT_EN to build the accepted-word counter.
module oc8051_cxrom_prefetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_load,
    input  logic [15:0] pc_in,
    output logic        cxrom_req,
    output logic [15:0] cxrom_addr,
    input  logic        cxrom_ack,
    input  logic [31:0] cxrom_data_in,
    output logic        op_valid,
    output logic [7:0]  op0,
    output logic [7:0]  op1,
    output logic [7:0]  op2,
    output logic [15:0] op_pc,
    input  logic [1:0]  op_adv,
    output logic [15:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  buf_q [8];
    logic [7:0]  buf_d [8];
    logic [2:0]  head_q, head_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] op_pc_q, op_pc_d;
    logic [15:0] fetch_addr_q, fetch_addr_d;
    logic [15:0] req_addr_q, req_addr_d;

    logic        valid_s;
    logic [2:0]  adv_s;
    logic [3:0]  count_ret_s;
    logic        fill_s;
    logic [2:0]  tail_s;
    logic [2:0]  head1_s;
    logic [2:0]  head2_s;

    // Decode window: depends on registered buffer state only.
    always_comb begin
        valid_s = (count_q >= 4'd3);
        head1_s = head_q + 3'd1;
        head2_s = head_q + 3'd2;
        if (valid_s) begin
            op0 = buf_q[head_q];
            op1 = buf_q[head1_s];
            op2 = buf_q[head2_s];
        end else begin
            op0 = 8'h00;
            op1 = 8'h00;
            op2 = 8'h00;
        end
    end

    assign op_valid   = valid_s;
    assign op_pc      = op_pc_q;
    assign cxrom_req  = (state_q != ST_IDLE);
    assign cxrom_addr = req_addr_q;

    // Retire, fill, request sequencing and redirect handling.
    always_comb begin
        adv_s        = valid_s ? {1'b0, op_adv} : 3'd0;
        count_ret_s  = count_q - {1'b0, adv_s};
        fill_s       = (state_q == ST_REQ) && cxrom_ack && !pc_load;
        tail_s       = head_q + count_q[2:0];

        state_d      = state_q;
        buf_d        = buf_q;
        head_d       = head_q + adv_s;
        count_d      = count_ret_s;
        op_pc_d      = op_pc_q + {13'd0, adv_s};
        fetch_addr_d = fetch_addr_q;
        req_addr_d   = req_addr_q;

        // The issue rule keeps count <= 4 while a request is open, so a fill never overflows.
        if (fill_s) begin
            buf_d[tail_s]        = cxrom_data_in[7:0];
            buf_d[tail_s + 3'd1] = cxrom_data_in[15:8];
            buf_d[tail_s + 3'd2] = cxrom_data_in[23:16];
            buf_d[tail_s + 3'd3] = cxrom_data_in[31:24];
            count_d              = count_ret_s + 4'd4;
            fetch_addr_d         = fetch_addr_q + 16'd4;
        end else begin
            count_d              = count_ret_s;
        end

        case (state_q)
            ST_IDLE: begin
                if (count_ret_s <= 4'd4) begin
                    state_d    = ST_REQ;
                    req_addr_d = fetch_addr_q;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!cxrom_ack) begin
                    state_d    = ST_REQ;
                end else if (count_d <= 4'd4) begin
                    state_d    = ST_REQ;
                    req_addr_d = fetch_addr_d;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (cxrom_ack) begin
                    state_d    = ST_REQ;
                    req_addr_d = fetch_addr_q;
                end else begin
                    state_d    = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect wins; an unacked open request must still complete at its old address.
        if (pc_load) begin
            count_d      = 4'd0;
            head_d       = 3'd0;
            op_pc_d      = pc_in;
            fetch_addr_d = pc_in;
            if ((state_q != ST_IDLE) && !cxrom_ack) begin
                state_d    = ST_DISCARD;
                req_addr_d = req_addr_q;
            end else begin
                state_d    = ST_REQ;
                req_addr_d = pc_in;
            end
        end else begin
            count_d      = count_d;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            head_q       <= 3'd0;
            count_q      <= 4'd0;
            op_pc_q      <= 16'h0000;
            fetch_addr_q <= 16'h0000;
            req_addr_q   <= 16'h0000;
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            count_q      <= count_d;
            op_pc_q      <= op_pc_d;
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

`ifdef OC8051_CXROM_PREFETCH_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of words actually kept in the buffer.
    always_comb begin
        if (fill_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register; cleared by reset only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_cnt = cnt_q;
`else
    assign fetch_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_oc8051_cxrom_prefetch.sv
// Bench for oc8051_cxrom_prefetch: table vectors, directed redirect/stall/reset sequences and
// random traffic against a byte-queue reference model. ROM content is ROM[a] = a[7:0].
module tb_oc8051_cxrom_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic        cxrom_req;
    logic [15:0] cxrom_addr;
    logic        cxrom_ack = 1'b0;
    logic [31:0] cxrom_data_in = 32'h0;
    logic        op_valid;
    logic [7:0]  op0, op1, op2;
    logic [15:0] op_pc;
    logic [1:0]  op_adv = 2'd0;
    logic [15:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    oc8051_cxrom_prefetch dut (
        .clk(clk), .rst(rst), .pc_load(pc_load), .pc_in(pc_in),
        .cxrom_req(cxrom_req), .cxrom_addr(cxrom_addr), .cxrom_ack(cxrom_ack),
        .cxrom_data_in(cxrom_data_in), .op_valid(op_valid), .op0(op0), .op1(op1),
        .op2(op2), .op_pc(op_pc), .op_adv(op_adv), .fetch_cnt(fetch_cnt)
    );

    function automatic logic [7:0] rom(input logic [15:0] a);
        return a[7:0];
    endfunction

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {rom(a + 16'd3), rom(a + 16'd2), rom(a + 16'd1), rom(a)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a queue of bytes, the fetcher a few flags.
    logic        m_live = 1'b0;
    logic        m_req, m_stale;
    logic [15:0] m_addr, m_fetch, m_pc, m_cnt;
    logic [7:0]  mq[$];

    function automatic logic [15:0] exp_cnt();
`ifdef OC8051_CXROM_PREFETCH_CNT_EN
        return m_cnt;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_check();
        logic v;
        v = (mq.size() >= 3);
        chk("m_req", 32'(cxrom_req), 32'(m_req));
        if (m_req) chk("m_addr", 32'(cxrom_addr), 32'(m_addr));
        chk("m_valid", 32'(op_valid), 32'(v));
        chk("m_op0", 32'(op0), v ? 32'(mq[0]) : 32'h0);
        chk("m_op1", 32'(op1), v ? 32'(mq[1]) : 32'h0);
        chk("m_op2", 32'(op2), v ? 32'(mq[2]) : 32'h0);
        chk("m_pc", 32'(op_pc), 32'(m_pc));
        chk("m_cnt", 32'(fetch_cnt), 32'(exp_cnt()));
    endtask

    task automatic model_update(input logic r, input logic pl, input logic [15:0] pcv,
                                input logic ack, input logic [1:0] adv);
        int n;
        if (r) begin
            m_live = 1'b1; m_req = 1'b0; m_stale = 1'b0;
            m_addr = 16'h0; m_fetch = 16'h0; m_pc = 16'h0; m_cnt = 16'h0;
            mq.delete();
        end else if (pl) begin
            mq.delete();
            m_pc = pcv;
            m_fetch = pcv;
            if (m_req && !ack) begin
                m_stale = 1'b1;
            end else begin
                m_req = 1'b1; m_stale = 1'b0; m_addr = pcv;
            end
        end else begin
            n = (mq.size() >= 3) ? int'(adv) : 0;
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            m_pc = m_pc + 16'(n);
            if (m_req) begin
                if (ack && m_stale) begin
                    m_stale = 1'b0;
                    m_addr = m_fetch;
                end else if (ack) begin
                    for (int k = 0; k < 4; k++) mq.push_back(rom(m_addr + 16'(k)));
                    m_fetch = m_fetch + 16'd4;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    m_req = (mq.size() <= 4);
                    if (m_req) m_addr = m_fetch;
                end
            end else if (mq.size() <= 4) begin
                m_req = 1'b1;
                m_addr = m_fetch;
            end
        end
        if (mq.size() > 8) begin
            errors++;
            $display("FAIL model_overflow: got %0d bytes expected at most 8", mq.size());
        end
    endtask

    // One clock: drive at negedge, check model, clock, advance model.
    task automatic step(input logic r, input logic pl, input logic [15:0] pcv,
                        input logic ack_en, input logic [1:0] adv);
        rst = r; pc_load = pl; pc_in = pcv; op_adv = adv;
        cxrom_ack = ack_en & cxrom_req;
        cxrom_data_in = rom_word(cxrom_addr);
        if (m_live) model_check();
        @(posedge clk);
        model_update(r, pl, pcv, cxrom_ack, adv);
        @(negedge clk);
    endtask

    typedef struct {
        logic        r;
        logic        ack;
        logic [1:0]  adv;
        logic        chk_en;
        logic        chk_addr;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [7:0]  e_op0;
        logic [15:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic ack, input logic [1:0] adv,
                                input logic ce, input logic ca, input logic er,
                                input logic [15:0] ea, input logic ev, input logic [7:0] e0,
                                input logic [15:0] ep);
        vec_t v;
        v.r = r; v.ack = ack; v.adv = adv; v.chk_en = ce; v.chk_addr = ca;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_op0 = e0; v.e_pc = ep;
        return v;
    endfunction

    vec_t vecs[13];
    logic [15:0] cnt_snap;

    initial begin
        // Expected outputs are those seen before the row's inputs are clocked in.
        vecs[0]  = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000);
        vecs[1]  = mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000);
        vecs[2]  = mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000);
        vecs[3]  = mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000);
        vecs[4]  = mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 8'h00, 16'h0000);
        vecs[5]  = mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h0000);
        vecs[6]  = mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h03, 16'h0003);
        vecs[7]  = mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 16'h0008, 1'b0, 8'h00, 16'h0006);
        vecs[8]  = mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h06, 16'h0006);
        vecs[9]  = mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 16'h000C, 1'b1, 8'h09, 16'h0009);
        vecs[10] = mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 16'h0010, 1'b1, 8'h0C, 16'h000C);
        vecs[11] = mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h0F, 16'h000F);
        vecs[12] = mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 16'h0014, 1'b0, 8'h00, 16'h0012);

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].chk_en) begin
                chk($sformatf("t%0d_req", i), 32'(cxrom_req), 32'(vecs[i].e_req));
                if (vecs[i].chk_addr) chk($sformatf("t%0d_addr", i), 32'(cxrom_addr), 32'(vecs[i].e_addr));
                chk($sformatf("t%0d_valid", i), 32'(op_valid), 32'(vecs[i].e_valid));
                chk($sformatf("t%0d_op0", i), 32'(op0), 32'(vecs[i].e_op0));
                chk($sformatf("t%0d_pc", i), 32'(op_pc), 32'(vecs[i].e_pc));
            end
            step(vecs[i].r, 1'b0, 16'h0000, vecs[i].ack, vecs[i].adv);
        end

        // Ack stall while retiring one byte per cycle.
        step(1'b0, 1'b1, 16'h0100, 1'b1, 2'd0);
        chk("stall_addr0", 32'(cxrom_addr), 32'h0100);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 2'd1);
        chk("stall_valid", 32'(op_valid), 32'h0);
        chk("stall_req", 32'(cxrom_req), 32'h1);
        chk("stall_addr", 32'(cxrom_addr), 32'h0104);
        chk("stall_pc", 32'(op_pc), 32'h0102);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd0);
        chk("stall_refill_valid", 32'(op_valid), 32'h1);
        chk("stall_refill_op0", 32'(op0), 32'h02);

        // Redirect across the top of the address space.
        step(1'b0, 1'b1, 16'hFFFE, 1'b1, 2'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd0);
        chk("wrap_op0", 32'(op0), 32'hFE);
        chk("wrap_op1", 32'(op1), 32'hFF);
        chk("wrap_op2", 32'(op2), 32'h00);
        chk("wrap_pc", 32'(op_pc), 32'hFFFE);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 2'd3);
        chk("wrap_pc_adv", 32'(op_pc), 32'h0001);
        chk("wrap_fetch_addr", 32'(cxrom_addr), 32'h0002);

        // Redirect while a request waits: the late word must be dropped.
        step(1'b0, 1'b1, 16'h2000, 1'b1, 2'd0);
        cnt_snap = m_cnt;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 2'd0);
        step(1'b0, 1'b1, 16'h1234, 1'b0, 2'd0);
        chk("disc_hold_req", 32'(cxrom_req), 32'h1);
        chk("disc_hold_addr", 32'(cxrom_addr), 32'h2000);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 2'd0);
        chk("disc_hold_addr2", 32'(cxrom_addr), 32'h2000);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd0);
        chk("disc_new_addr", 32'(cxrom_addr), 32'h1234);
        chk("disc_no_data", 32'(op_valid), 32'h0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd0);
        chk("disc_op0", 32'(op0), 32'h34);
        chk("disc_pc", 32'(op_pc), 32'h1234);
`ifdef OC8051_CXROM_PREFETCH_CNT_EN
        chk("disc_cnt", 32'(fetch_cnt), 32'(cnt_snap + 16'd1));
`else
        chk("disc_cnt", 32'(fetch_cnt), 32'h0);
`endif

        // Redirect coinciding with an ack.
        step(1'b0, 1'b1, 16'h3000, 1'b1, 2'd0);
        chk("same_addr1", 32'(cxrom_addr), 32'h3000);
        step(1'b0, 1'b1, 16'h4000, 1'b1, 2'd0);
        chk("same_req", 32'(cxrom_req), 32'h1);
        chk("same_addr2", 32'(cxrom_addr), 32'h4000);
        chk("same_valid", 32'(op_valid), 32'h0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd0);
        chk("same_op0", 32'(op0), 32'h00);
        chk("same_pc", 32'(op_pc), 32'h4000);

        // Reset in the middle of an open request.
        step(1'b0, 1'b1, 16'h5000, 1'b0, 2'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd0);
        chk("rst_pre_addr", 32'(cxrom_addr), 32'h5000);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 2'd0);
        chk("rst_req", 32'(cxrom_req), 32'h0);
        chk("rst_addr", 32'(cxrom_addr), 32'h0);
        chk("rst_valid", 32'(op_valid), 32'h0);
        chk("rst_ops", {8'h00, op0, op1, op2}, 32'h0);
        chk("rst_pc", 32'(op_pc), 32'h0);
        chk("rst_cnt", 32'(fetch_cnt), 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r, pl, ae;
            logic [15:0] pv;
            r  = ($urandom_range(0, 199) == 0);
            pl = ($urandom_range(0, 24) == 0);
            pv = ($urandom_range(0, 3) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7)))
                                             : 16'($urandom);
            ae = ($urandom_range(0, 9) < 7);
            step(r, pl, pv, ae, 2'($urandom_range(0, 3)));
        end
        step(1'b0, 1'b0, 16'h0000, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
